// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter:
// FSM state codes, read-owner codes and default widths.
package mem_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 8;

    localparam logic [1:0] ARB      = 2'd0;
    localparam logic [1:0] LOCK_CPU = 2'd1;
    localparam logic [1:0] LOCK_IO  = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

endpackage

// File: rtl/wait_counter.sv
// Saturating wait counter for one requester; hit_o flags
// that the requester has waited MAX cycles and must win.
module wait_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req_i,
    input  logic gnt_i,
    output logic hit_o
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count ungranted request cycles, clear on grant or idle.
    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != W'(MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the CPU and the I/O
// engine: grant, lock, starvation override, read steering.
module ram_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_lock,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              io_req,
    input  logic              io_lock,
    input  logic              io_we,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              ptr_q;
    logic              tag_v_q;
    logic              tag_own_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cpu_hit;
    logic              io_hit;
    logic              force_c;
    logic              force_i;
    logic              any_gnt;
    logic              gnt_we;

    wait_counter #(.MAX(MAX_WAIT)) u_cpu_wait (
        .clk   (clk),
        .reset (reset),
        .req_i (cpu_req),
        .gnt_i (cpu_gnt),
        .hit_o (cpu_hit)
    );

    wait_counter #(.MAX(MAX_WAIT)) u_io_wait (
        .clk   (clk),
        .reset (reset),
        .req_i (io_req),
        .gnt_i (io_gnt),
        .hit_o (io_hit)
    );

    assign force_c = cpu_hit && cpu_req;
    assign force_i = io_hit && io_req;

    // Pick the winner: starvation override, then lock, then round-robin.
    always_comb begin
        cpu_gnt = 1'b0;
        io_gnt  = 1'b0;
        if (!reset) begin
            if (force_c && force_i) begin
                cpu_gnt = (ptr_q == OWN_IO);
                io_gnt  = (ptr_q == OWN_CPU);
            end else if (force_c || force_i) begin
                cpu_gnt = force_c;
                io_gnt  = force_i;
            end else begin
                case (state_q)
                    LOCK_CPU: cpu_gnt = cpu_req;
                    LOCK_IO:  io_gnt  = io_req;
                    default: begin
                        if (cpu_req && io_req) begin
                            cpu_gnt = (ptr_q == OWN_IO);
                            io_gnt  = (ptr_q == OWN_CPU);
                        end else begin
                            cpu_gnt = cpu_req;
                            io_gnt  = io_req;
                        end
                    end
                endcase
            end
        end
    end

    // Next FSM state: a forced win or any ungranted cycle returns to ARB.
    always_comb begin
        state_d = ARB;
        if (!(force_c || force_i)) begin
            if (cpu_gnt && cpu_lock) begin
                state_d = LOCK_CPU;
            end else if (io_gnt && io_lock) begin
                state_d = LOCK_IO;
            end
        end
    end

    assign any_gnt = cpu_gnt || io_gnt;
    assign gnt_we  = cpu_gnt ? cpu_we : io_we;

    // Drive the RAM port from the granted side, else hold the address.
    always_comb begin
        ram_address = addr_q;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (cpu_gnt) begin
            ram_address = cpu_addr;
            ram_data    = cpu_wdata;
            ram_wren    = cpu_we;
        end else if (io_gnt) begin
            ram_address = io_addr;
            ram_data    = io_wdata;
            ram_wren    = io_we;
        end
    end

    // State, round-robin pointer, held address and read tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= OWN_IO;
            tag_v_q   <= 1'b0;
            tag_own_q <= OWN_CPU;
            addr_q    <= '0;
        end else begin
            state_q <= state_d;
            tag_v_q <= any_gnt && !gnt_we;
            if (any_gnt) begin
                ptr_q     <= io_gnt ? OWN_IO : OWN_CPU;
                tag_own_q <= io_gnt ? OWN_IO : OWN_CPU;
                addr_q    <= ram_address;
            end
        end
    end

    // A pending tag is dropped while reset is asserted.
    assign cpu_rvalid = tag_v_q && !reset && (tag_own_q == OWN_CPU);
    assign io_rvalid  = tag_v_q && !reset && (tag_own_q == OWN_IO);
    assign cpu_rdata  = cpu_rvalid ? ram_q : '0;
    assign io_rdata   = io_rvalid ? ram_q : '0;

endmodule
